imem_loader: RTL and testbench

Program loader that writes instruction words into instruction memory: the write-side counterpart of the fetch path, which only reads instruction memory. It accepts a stream of 10-bit instruction words over a valid/ready handshake, writes them to consecutive instruction-memory addresses starting at a programmable base, and verifies a trailing checksum word. It holds the CPU (fetch unit PC register) in reset until a load completes cleanly.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_if.sv | 18 +
 rtl/imem_checksum_acc.sv | 21 ++
 rtl/imem_loader.sv | 115 +++++++++++
 tb/tb_imem_loader.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// The checksum is the DATA_W-bit wrapping sum of all program words.
package imem_loader_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 10;
    localparam int CNT_W_DEF  = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Stream input and instruction-memory write port of the loader.
// slave = loader side, master = stream source / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = imem_loader_pkg::ADDR_W_DEF,
    parameter int DATA_W = imem_loader_pkg::DATA_W_DEF
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport slave  (input  in_valid, in_data,
                    output in_ready, mem_we, mem_addr, mem_wdata);
    modport master (output in_valid, in_data,
                    input  in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_checksum_acc.sv
// Wrapping accumulator for the program checksum; clear has priority over enable.
module imem_checksum_acc #(
    parameter int W = imem_loader_pkg::DATA_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_en,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_sum
);
    logic [W-1:0] r_sum;

    always_ff @(posedge clk) begin
        if (!reset)       r_sum <= '0;
        else if (i_clear) r_sum <= '0;
        else if (i_en)    r_sum <= r_sum + i_data;
    end

    assign o_sum = r_sum;
endmodule

// File: rtl/imem_loader.sv
// Streams program words into instruction memory from a base address, verifies
// the trailing checksum and keeps the CPU in reset until a clean load ends.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    imem_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);
    ld_state_t         r_state, w_next;
    logic              w_ready;
    logic              w_start;
    logic              w_load_hs;
    logic              w_chk_hs;
    logic [DATA_W-1:0] w_sum;

    logic [ADDR_W-1:0] r_addr_ptr;
    logic [CNT_W-1:0]  r_remaining;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_error;
    logic              r_cpu_hold;

    assign w_start   = (r_state == ST_IDLE) && start;
    assign w_load_hs = (r_state == ST_LOAD) && bus.in_valid;
    assign w_chk_hs  = (r_state == ST_CHECK) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // in_ready is decoded from state alone so the source never sees a
    // combinational path back from its own valid.
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = (word_count != '0) ? ST_LOAD : ST_CHECK;
            end
            ST_LOAD: begin
                w_ready = 1'b1;
                if (bus.in_valid && (r_remaining == CNT_W'(1))) w_next = ST_CHECK;
            end
            ST_CHECK: begin
                w_ready = 1'b1;
                if (bus.in_valid) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr_ptr  <= '0;
            r_remaining <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_error     <= 1'b0;
            r_cpu_hold  <= 1'b1;
        end else begin
            r_mem_we <= w_load_hs;
            if (w_start) begin
                r_addr_ptr  <= base_addr;
                r_remaining <= word_count;
                r_error     <= 1'b0;
                r_cpu_hold  <= 1'b1;
            end
            if (w_load_hs) begin
                r_mem_addr  <= r_addr_ptr;
                r_mem_wdata <= bus.in_data;
                r_addr_ptr  <= r_addr_ptr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
            if (w_chk_hs) r_error <= (bus.in_data != w_sum);
            // A failed load leaves the CPU held until a later load succeeds.
            if (r_state == ST_DONE) r_cpu_hold <= r_error;
        end
    end

    imem_checksum_acc #(.W(DATA_W)) u_acc (
        .clk    (clk),
        .reset  (reset),
        .i_clear(w_start),
        .i_en   (w_load_hs),
        .i_data (bus.in_data),
        .o_sum  (w_sum)
    );

    assign bus.in_ready  = w_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign cpu_hold      = r_cpu_hold;
    assign busy          = (r_state == ST_LOAD) || (r_state == ST_CHECK);
    assign done          = (r_state == ST_DONE);
    assign error         = r_error;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: expected writes, checksum outcome and CPU
// hold are derived from the load rules with plain arithmetic and queues.
module tb_imem_loader;
    localparam int AW = 10;
    localparam int DW = 10;
    localparam int CW = 11;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [31:0]   c;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] word_count = '0;
    logic          cpu_hold, busy, done, error;

    imem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    imem_loader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .word_count(word_count),
        .bus       (bus),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wr_t exp_q[$];
    wr_t act_q[$];
    wr_t mon_w;
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            mon_w.a = bus.mem_addr;
            mon_w.d = bus.mem_wdata;
            mon_w.c = cyc;
            act_q.push_back(mon_w);
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [DW-1:0] stim_q[$];
    bit  m_err;
    bit  o_timeout, o_done, o_err, o_busy, o_hold, o_done_after;
    bit  o_s_err, o_s_busy, o_s_hold;
    int  o_rdy_low;

    // Fill stim_q with n random words plus a correct (or deliberately wrong) checksum.
    task automatic make_stim(input int n, input bit bad);
        int s;
        logic [DW-1:0] w;
        s = 0;
        stim_q.delete();
        for (int i = 0; i < n; i++) begin
            w = DW'($urandom);
            stim_q.push_back(w);
            s = (s + int'(w)) % (1 << DW);
        end
        if (bad) stim_q.push_back(DW'(s) ^ DW'($urandom_range(1, (1 << DW) - 1)));
        else     stim_q.push_back(DW'(s));
        m_err = bad;
    endtask

    function automatic int first_diff();
        if (exp_q.size() != act_q.size()) return -2;
        foreach (exp_q[i]) if (exp_q[i] !== act_q[i]) return i;
        return -1;
    endfunction

    // Runs one load. stall: 0 none, 1 toggle, 2 random. abort_after>=0 stops
    // after that many words with the loader still in LOAD.
    task automatic run_load(input int b, input int n, input int stall,
                            input int abort_after, input bit poke);
        int idx, guard;
        bit v, rdy, tog;
        wr_t w;
        idx = 0; guard = 0; tog = 1'b1;
        o_timeout = 0; o_rdy_low = 0;
        exp_q.delete(); act_q.delete();
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(b); word_count = CW'(n);
        @(posedge clk); #1;
        start = 1'b0;
        o_s_err = error; o_s_busy = busy; o_s_hold = cpu_hold;
        base_addr = AW'($urandom); word_count = CW'($urandom);
        while (idx <= n) begin
            if (abort_after >= 0 && idx == abort_after) break;
            if (guard > 400) begin o_timeout = 1; break; end
            guard++;
            case (stall)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            bus.in_valid = v;
            bus.in_data  = v ? stim_q[idx] : DW'($urandom);
            start = poke && (idx == 1);
            @(negedge clk);
            rdy = bus.in_ready;
            if (!rdy) o_rdy_low++;
            @(posedge clk); #1;
            if (v && rdy) begin
                if (idx < n) begin
                    w.a = AW'((b + idx) % (1 << AW));
                    w.d = stim_q[idx];
                    w.c = cyc;
                    exp_q.push_back(w);
                end
                idx++;
            end
        end
        bus.in_valid = 1'b0;
        start = 1'b0;
        if (abort_after >= 0 || o_timeout) return;
        @(negedge clk);
        o_done = done; o_err = error; o_busy = busy;
        @(posedge clk);
        @(negedge clk);
        o_done_after = done; o_hold = cpu_hold;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; base_addr = 10'h155; word_count = 11'd9;
        bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (cpu_hold !== 1'b1) $display("FAIL reset_hold got=%b exp=1", cpu_hold); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.mem_we !== 1'b0) $display("FAIL reset_we got=%b exp=0", bus.mem_we); else pass_cnt++;
        total_cnt++; if (error !== 1'b0) $display("FAIL reset_error got=%b exp=0", error); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); else pass_cnt++;
        total_cnt++; if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) $display("FAIL reset_mem got=%h/%h exp=0/0", bus.mem_addr, bus.mem_wdata); else pass_cnt++;
        act_q.delete();
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 10'h3A5;
        repeat (2) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_start_ignored busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (act_q.size() != 0) $display("FAIL idle_valid_ignored writes got=%0d exp=0", act_q.size()); else pass_cnt++;
    endtask

    task automatic test_basic();
        stim_q = '{10'h001, 10'h002, 10'h003, 10'h006};
        run_load(0, 3, 0, -1, 0);
        total_cnt++; if (o_timeout) $display("FAIL basic_timeout got=1 exp=0"); else pass_cnt++;
        total_cnt++; if (o_s_busy !== 1'b1 || o_s_hold !== 1'b1) $display("FAIL basic_after_start busy/hold got=%b/%b exp=1/1", o_s_busy, o_s_hold); else pass_cnt++;
        total_cnt++; if (o_rdy_low != 0) $display("FAIL basic_ready_low got=%0d exp=0", o_rdy_low); else pass_cnt++;
        total_cnt++; if (first_diff() != -1) $display("FAIL basic_writes diff=%0d act=%0d exp=%0d", first_diff(), act_q.size(), exp_q.size()); else pass_cnt++;
        total_cnt++; if (act_q.size() == 3 && (act_q[2].a !== 10'd2 || act_q[2].d !== 10'h003 || act_q[2].c != act_q[0].c + 2))
            $display("FAIL basic_last_write got=%h/%h exp=002/003", act_q[2].a, act_q[2].d); else pass_cnt++;
        total_cnt++; if (o_done !== 1'b1 || o_err !== 1'b0 || o_busy !== 1'b0) $display("FAIL basic_done done/err/busy got=%b/%b/%b exp=1/0/0", o_done, o_err, o_busy); else pass_cnt++;
        total_cnt++; if (o_done_after !== 1'b0) $display("FAIL basic_done_pulse got=%b exp=0", o_done_after); else pass_cnt++;
        total_cnt++; if (o_hold !== 1'b0) $display("FAIL basic_hold got=%b exp=0", o_hold); else pass_cnt++;
    endtask

    task automatic test_bad_checksum();
        stim_q = '{10'h001, 10'h002, 10'h003, 10'h007};
        run_load(0, 3, 0, -1, 0);
        total_cnt++; if (first_diff() != -1) $display("FAIL bad_writes diff=%0d act=%0d exp=%0d", first_diff(), act_q.size(), exp_q.size()); else pass_cnt++;
        total_cnt++; if (o_done !== 1'b1 || o_err !== 1'b1) $display("FAIL bad_done_err got=%b/%b exp=1/1", o_done, o_err); else pass_cnt++;
        total_cnt++; if (o_hold !== 1'b1) $display("FAIL bad_hold got=%b exp=1", o_hold); else pass_cnt++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (error !== 1'b1) $display("FAIL bad_error_sticky got=%b exp=1", error); else pass_cnt++;
    endtask

    task automatic test_wrap_stall();
        make_stim(4, 1'b0);
        run_load(1022, 4, 1, -1, 0);
        total_cnt++; if (o_s_err !== 1'b0) $display("FAIL wrap_error_cleared got=%b exp=0", o_s_err); else pass_cnt++;
        total_cnt++; if (first_diff() != -1) $display("FAIL wrap_writes diff=%0d act=%0d exp=%0d", first_diff(), act_q.size(), exp_q.size()); else pass_cnt++;
        total_cnt++; if (act_q.size() == 4 && (act_q[1].a !== 10'd1023 || act_q[2].a !== 10'd0 || act_q[3].a !== 10'd1))
            $display("FAIL wrap_addr got=%0d,%0d,%0d exp=1023,0,1", act_q[1].a, act_q[2].a, act_q[3].a); else pass_cnt++;
        total_cnt++; if (o_err !== 1'b0 || o_hold !== 1'b0) $display("FAIL wrap_result err/hold got=%b/%b exp=0/0", o_err, o_hold); else pass_cnt++;
    endtask

    task automatic test_reset_midload();
        make_stim(5, 1'b0);
        run_load(10'h200, 5, 0, 2, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        total_cnt++; if (first_diff() != -1) $display("FAIL midrst_writes diff=%0d act=%0d exp=%0d", first_diff(), act_q.size(), exp_q.size()); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || cpu_hold !== 1'b1) $display("FAIL midrst_state busy/hold got=%b/%b exp=0/1", busy, cpu_hold); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0) $display("FAIL midrst_ready_we got=%b/%b exp=0/0", bus.in_ready, bus.mem_we); else pass_cnt++;
        make_stim(3, 1'b0);
        run_load(10'h100, 3, 0, -1, 0);
        total_cnt++; if (first_diff() != -1 || act_q.size() == 0 || act_q[0].a !== 10'h100)
            $display("FAIL midrst_reload diff=%0d act=%0d exp=%0d", first_diff(), act_q.size(), exp_q.size()); else pass_cnt++;
        total_cnt++; if (o_err !== 1'b0 || o_hold !== 1'b0) $display("FAIL midrst_reload_result got=%b/%b exp=0/0", o_err, o_hold); else pass_cnt++;
    endtask

    task automatic test_zero_count();
        stim_q = '{10'h000};
        run_load(5, 0, 0, -1, 0);
        total_cnt++; if (o_timeout) $display("FAIL zero_timeout got=1 exp=0"); else pass_cnt++;
        total_cnt++; if (act_q.size() != 0) $display("FAIL zero_writes got=%0d exp=0", act_q.size()); else pass_cnt++;
        total_cnt++; if (o_s_busy !== 1'b1) $display("FAIL zero_busy_after_start got=%b exp=1", o_s_busy); else pass_cnt++;
        total_cnt++; if (o_done !== 1'b1 || o_err !== 1'b0 || o_hold !== 1'b0) $display("FAIL zero_result done/err/hold got=%b/%b/%b exp=1/0/0", o_done, o_err, o_hold); else pass_cnt++;
    endtask

    task automatic test_start_during_load();
        make_stim(4, 1'b0);
        run_load(10'h050, 4, 0, -1, 1);
        total_cnt++; if (first_diff() != -1) $display("FAIL poke_writes diff=%0d act=%0d exp=%0d", first_diff(), act_q.size(), exp_q.size()); else pass_cnt++;
        total_cnt++; if (o_done !== 1'b1 || o_err !== 1'b0) $display("FAIL poke_result done/err got=%b/%b exp=1/0", o_done, o_err); else pass_cnt++;
    endtask

    task automatic test_random();
        int b, n;
        bit bad;
        for (int it = 0; it < 8; it++) begin
            b   = $urandom_range(0, (1 << AW) - 1);
            n   = $urandom_range(1, 12);
            bad = ($urandom_range(0, 1) == 1);
            make_stim(n, bad);
            run_load(b, n, 2, -1, 0);
            total_cnt++; if (o_timeout || first_diff() != -1) $display("FAIL rand%0d_writes diff=%0d act=%0d exp=%0d", it, first_diff(), act_q.size(), exp_q.size()); else pass_cnt++;
            total_cnt++; if (o_done !== 1'b1 || o_err !== m_err || o_hold !== m_err)
                $display("FAIL rand%0d_result done/err/hold got=%b/%b/%b exp=1/%b/%b", it, o_done, o_err, o_hold, m_err, m_err); else pass_cnt++;
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_basic();
        test_bad_checksum();
        test_wrap_stall();
        test_reset_midload();
        test_zero_count();
        test_start_during_load();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end
endmodule
